// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32I core.
// Handles load-use stalls, forwarding, memory freeze, branch flush and drain-to-halt.
module hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      id_inst,
   input  logic             id_valid,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic             mem_req,
   input  logic             dmem_ready,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   output logic             pc_write,
   output logic             pc_sel_target,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RUN, S_MEM_WAIT, S_DRAIN, S_HALT
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [DW-1:0]   drain_cnt;
   logic            drain_load;
   logic            drain_dec;
   logic            stall_hit;
   logic            flush_hit;
   logic            use_rs1;
   logic            use_rs2;
   logic            is_system;
   logic            load_use;
   logic            mem_freeze;
   logic            freeze;
   logic [6:0]      opcode;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic            unused_bits;

   assign opcode      = id_inst[6:0];
   assign id_rs1      = id_inst[19:15];
   assign id_rs2      = id_inst[24:20];
   assign unused_bits = ^{id_inst[31:25], id_inst[14:7]};

   // Decode which source registers the ID instruction reads
   always_comb begin
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      is_system = 1'b0;
      if (id_valid) begin
         case (opcode)
            OP_OP, OP_STORE, OP_BRANCH: begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
            OP_SYSTEM:                is_system = 1'b1;
            default:                  ;
         endcase
      end
   end

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((use_rs1 && (id_rs1 == ex_rd)) ||
                      (use_rs2 && (id_rs2 == ex_rd)));

   assign mem_freeze = mem_req && !dmem_ready;
   // Once waiting, only dmem_ready releases the freeze
   assign freeze = (state == S_MEM_WAIT) ? !dmem_ready : mem_freeze;

   // Operand forwarding; the younger EX/MEM result takes precedence
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
         fwd_a = 2'b10;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
         fwd_a = 2'b01;
      if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
         fwd_b = 2'b10;
      else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
         fwd_b = 2'b01;
   end

   // Pipeline enables, flushes and next-state selection
   always_comb begin
      pc_write      = 1'b1;
      pc_sel_target = 1'b0;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_write  = 1'b1;
      next_state    = state;
      drain_load    = 1'b0;
      drain_dec     = 1'b0;
      stall_hit     = 1'b0;
      flush_hit     = 1'b0;
      unique case (state)
         S_RUN, S_MEM_WAIT: begin
            if (freeze) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_write = 1'b0;
               mem_wb_write = 1'b0;
               stall_hit    = 1'b1;
               next_state   = S_MEM_WAIT;
            end else begin
               next_state = S_RUN;
               if (ex_branch_taken) begin
                  pc_sel_target = 1'b1;
                  if_id_flush   = 1'b1;
                  id_ex_flush   = 1'b1;
                  flush_hit     = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
                  stall_hit   = 1'b1;
               end else if (is_system) begin
                  next_state = S_DRAIN;
                  drain_load = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (mem_freeze) begin
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_write = 1'b0;
               mem_wb_write = 1'b0;
               stall_hit    = 1'b1;
            end else if (drain_cnt == '0) begin
               next_state = S_HALT;
            end else begin
               drain_dec = 1'b1;
            end
         end
         S_HALT: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
         end
      endcase
   end

   // State, drain counter, halt flag and saturating perf counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_RUN;
         drain_cnt    <= '0;
         halted       <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state  <= next_state;
         halted <= (next_state == S_HALT);
         if (drain_load)
            drain_cnt <= DRAIN_INIT;
         else if (drain_dec)
            drain_cnt <= drain_cnt - DW'(1);
         if (stall_hit && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_hit && flush_count != {CNT_W{1'b1}})
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
